sound_event_sched: RTL and testbench

Schedules the on-board sound generators (LFSR crash voice, DDS tone voices) from the processor's sound PIO bits. It converts level/edge requests into timed enable windows, arbitrates a limited number of simultaneous voices by fixed priority, and supports retrigger and preemption. It sits between the PIO output port and the generators' reset inputs (generator reset = ~voice_run[i]). It runs on the audio sample clock (DAC LR clock).

---
 rtl/sound_sched_pkg.sv | 17 +
 rtl/sound_event_sched_voice_timer.sv | 77 +++++++
 rtl/sound_event_sched.sv | 130 +++++++++++++
 tb/tb_sound_event_sched.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/sound_sched_pkg.sv
// rtl/sound_sched_pkg.sv - shared defaults and source indices for the sound event scheduler
package sound_sched_pkg;

  // Default geometry of the scheduler
  localparam int NUM_REQ_DEF    = 4;
  localparam int NUM_VOICES_DEF = 2;
  localparam int DUR_W_DEF      = 16;

  // Named request sources / generators
  localparam int SND_CRASH   = 0;
  localparam int SND_SUCCESS = 1;

  // Default durations in samples at 48 kHz
  localparam int CRASH_DUR   = 24000;
  localparam int SUCCESS_DUR = 12000;

endpackage

// File: rtl/sound_event_sched_voice_timer.sv
// rtl/sound_event_sched_voice_timer.sv - per-generator enable window: load, countdown, gating, retrigger gap
module voice_timer
  import sound_sched_pkg::*;
#(
  parameter int DUR_W = DUR_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             grant,
  input  logic             retrig,
  input  logic             kill,
  input  logic             gate,
  input  logic [DUR_W-1:0] dur,
  output logic             run,
  output logic             gap,
  output logic             expire,
  output logic             occ_next
);

  logic [DUR_W-1:0] cnt, cnt_d;
  logic             timed, timed_d;
  logic             run_d, gap_d;

  // A running voice ends when its count reaches one (timed) or its request level drops (gated);
  // a retrigger on the same edge keeps the voice alive, so it is not an expiry.
  always_comb begin
    expire = run & ~retrig & (timed ? (cnt == DUR_W'(1)) : ~gate);
  end

  // Next-state for the enable window; kill beats everything, the gap always restarts the voice.
  always_comb begin
    run_d   = run;
    gap_d   = gap;
    cnt_d   = cnt;
    timed_d = timed;
    if (kill) begin
      run_d = 1'b0;
      gap_d = 1'b0;
    end else if (gap) begin
      run_d   = 1'b1;
      gap_d   = 1'b0;
      cnt_d   = dur;
      timed_d = (dur != '0);
    end else if (retrig && run) begin
      run_d = 1'b0;
      gap_d = 1'b1;
    end else if (grant) begin
      run_d   = 1'b1;
      cnt_d   = dur;
      timed_d = (dur != '0);
    end else if (run) begin
      if (expire) begin
        run_d = 1'b0;
      end else if (timed) begin
        cnt_d = cnt - DUR_W'(1);
      end
    end
  end

  assign occ_next = run_d | gap_d;

  // State register for the window
  always_ff @(posedge clock) begin
    if (reset) begin
      run   <= 1'b0;
      gap   <= 1'b0;
      cnt   <= '0;
      timed <= 1'b0;
    end else begin
      run   <= run_d;
      gap   <= gap_d;
      cnt   <= cnt_d;
      timed <= timed_d;
    end
  end

endmodule

// File: rtl/sound_event_sched.sv
// rtl/sound_event_sched.sv - request sync, edge detect, pending, fixed-priority voice arbitration and preemption
module sound_event_sched
  import sound_sched_pkg::*;
#(
  parameter int NUM_REQ    = NUM_REQ_DEF,
  parameter int NUM_VOICES = NUM_VOICES_DEF,
  parameter int DUR_W      = DUR_W_DEF
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                req,
  input  logic [NUM_REQ*DUR_W-1:0]          dur_cfg,
  output logic [NUM_REQ-1:0]                voice_run,
  output logic [$clog2(NUM_VOICES+1)-1:0]   active_cnt,
  output logic                              busy,
  output logic                              preempt_pulse
);

  localparam int                CNT_W   = $clog2(NUM_VOICES + 1);
  localparam int                IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CNT_W-1:0]  MAX_ACT = CNT_W'(NUM_VOICES);

  logic [NUM_REQ-1:0] s1, s2, prev;
  logic [1:0]         settle;
  logic               settled;
  logic [NUM_REQ-1:0] rise, retrig;
  logic [NUM_REQ-1:0] pending, pending_d;
  logic [NUM_REQ-1:0] gap, expire, occ_next;
  logic [NUM_REQ-1:0] grant_oh, kill_oh;
  logic [IDX_W-1:0]   p_idx, q_idx;
  logic               have_p, have_q;
  logic               do_grant, do_preempt;
  logic [CNT_W-1:0]   cnt_next;

  // Levels already high across reset must not look like edges, so edge detection
  // stays masked until the sync chain and edge register have refilled.
  assign settled = (settle == 2'd3);
  assign rise    = s2 & ~prev & {NUM_REQ{settled}};
  assign retrig  = rise & voice_run;

  // Lowest-index pending source and highest-index running voice
  always_comb begin
    have_p = 1'b0;
    p_idx  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (pending[i]) begin
        have_p = 1'b1;
        p_idx  = IDX_W'(i);
      end
    end
    have_q = 1'b0;
    q_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (voice_run[i]) begin
        have_q = 1'b1;
        q_idx  = IDX_W'(i);
      end
    end
  end

  // One grant or one preemption per edge; slot count comes from registered state,
  // and any expiry on this edge holds off preemption because a slot is freeing anyway.
  always_comb begin
    do_grant   = have_p && (active_cnt < MAX_ACT);
    do_preempt = have_p && have_q && (active_cnt == MAX_ACT) && !(|expire) && (p_idx < q_idx);
    grant_oh   = '0;
    kill_oh    = '0;
    if (do_grant) begin
      grant_oh[p_idx] = 1'b1;
    end
    if (do_preempt) begin
      kill_oh[q_idx] = 1'b1;
    end
  end

  // Pending: new edges on idle voices queue up, edges on queued voices merge, grants dequeue
  assign pending_d = (pending & ~grant_oh) | (rise & ~(voice_run | gap));

  // Occupied slots after this edge; a voice in its retrigger gap still holds its slot
  always_comb begin
    cnt_next = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_next = cnt_next + CNT_W'(occ_next[i]);
    end
  end

  // Sync chain, edge register, pending set and registered status outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      s1            <= '0;
      s2            <= '0;
      prev          <= '0;
      settle        <= 2'd0;
      pending       <= '0;
      active_cnt    <= '0;
      busy          <= 1'b0;
      preempt_pulse <= 1'b0;
    end else begin
      s1            <= req;
      s2            <= s1;
      prev          <= s2;
      if (!settled) begin
        settle <= settle + 2'd1;
      end
      pending       <= pending_d;
      active_cnt    <= cnt_next;
      busy          <= (|occ_next) | (|pending_d);
      preempt_pulse <= do_preempt;
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_voice
    voice_timer #(
      .DUR_W(DUR_W)
    ) u_timer (
      .clock    (clock),
      .reset    (reset),
      .grant    (grant_oh[i]),
      .retrig   (retrig[i]),
      .kill     (kill_oh[i]),
      .gate     (s2[i]),
      .dur      (dur_cfg[i*DUR_W +: DUR_W]),
      .run      (voice_run[i]),
      .gap      (gap[i]),
      .expire   (expire[i]),
      .occ_next (occ_next[i])
    );
  end

endmodule

// File: tb/tb_sound_event_sched.sv
// tb/tb_sound_event_sched.sv - scoreboard bench: expected output transitions queued by stimulus, checked by a monitor
module tb_sound_event_sched;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = 4'b0000;
  logic [63:0] dur_cfg = '0;
  logic [3:0]  voice_run;
  logic [1:0]  active_cnt;
  logic        busy;
  logic        preempt_pulse;

  typedef struct {
    int         cyc;
    logic [7:0] val;
  } exp_t;

  exp_t       exp_q[$];
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  logic       done = 1'b0;
  logic [7:0] prev_out = 8'h00;

  sound_event_sched dut (
    .clock         (clock),
    .reset         (reset),
    .req           (req),
    .dur_cfg       (dur_cfg),
    .voice_run     (voice_run),
    .active_cnt    (active_cnt),
    .busy          (busy),
    .preempt_pulse (preempt_pulse)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Expected tuple {voice_run, active_cnt, busy, preempt_pulse} at absolute edge c
  task automatic push(input int c, input logic [3:0] r, input logic [1:0] a, input logic b, input logic p);
    exp_t e;
    e.cyc = c;
    e.val = {r, a, b, p};
    exp_q.push_back(e);
  endtask

  function automatic logic [63:0] durs(input logic [15:0] d3, input logic [15:0] d2,
                                       input logic [15:0] d1, input logic [15:0] d0);
    return {d3, d2, d1, d0};
  endfunction

  task automatic chk(input string nm, input int act, input int want);
    checks++;
    if (act != want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h at cycle %0d", nm, act, want, cyc);
    end
  endtask

  // Monitor: compare each output change against the next queued expectation
  always @(posedge clock) begin
    logic [7:0] cur;
    exp_t       e;
    #2;
    cur = {voice_run, active_cnt, busy, preempt_pulse};
    if (reset) chk("reset_state", int'(cur), 0);
    chk("voice_limit", int'($countones(voice_run) <= 2), 1);
    if (cur !== prev_out) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_change", int'(cur), int'(prev_out));
      end else begin
        e = exp_q.pop_front();
        chk("event_cycle", cyc, e.cyc);
        chk("event_value", int'(cur), int'(e.val));
      end
      prev_out = cur;
    end
    if (done) begin
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("missing_event", -1, e.cyc);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  // Stimulus: directed scenarios, each pushing its hand-computed output transitions
  initial begin
    int t;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (6) @(negedge clock);

    // Single timed voice, dur=5
    dur_cfg = durs(16'd0, 16'd0, 16'd0, 16'd5);
    @(negedge clock);
    t = cyc;
    push(t + 3, 4'b0000, 2'd0, 1'b1, 1'b0);
    push(t + 4, 4'b0001, 2'd1, 1'b1, 1'b0);
    push(t + 9, 4'b0000, 2'd0, 1'b0, 1'b0);
    req = 4'b0001;
    repeat (12) @(negedge clock);
    req = 4'b0000;
    repeat (6) @(negedge clock);

    // Gated voice 2 held for 10 cycles
    dur_cfg = durs(16'd0, 16'd0, 16'd0, 16'd0);
    t = cyc;
    push(t + 3,  4'b0000, 2'd0, 1'b1, 1'b0);
    push(t + 4,  4'b0100, 2'd1, 1'b1, 1'b0);
    push(t + 13, 4'b0000, 2'd0, 1'b0, 1'b0);
    req = 4'b0100;
    repeat (10) @(negedge clock);
    req = 4'b0000;
    repeat (8) @(negedge clock);

    // Retrigger of voice 1 (dur=20) on its eighth running cycle
    dur_cfg = durs(16'd0, 16'd0, 16'd20, 16'd0);
    t = cyc;
    push(t + 3,  4'b0000, 2'd0, 1'b1, 1'b0);
    push(t + 4,  4'b0010, 2'd1, 1'b1, 1'b0);
    push(t + 12, 4'b0000, 2'd1, 1'b1, 1'b0);
    push(t + 13, 4'b0010, 2'd1, 1'b1, 1'b0);
    push(t + 33, 4'b0000, 2'd0, 1'b0, 1'b0);
    req = 4'b0010;
    repeat (5) @(negedge clock);
    req = 4'b0000;
    repeat (4) @(negedge clock);
    req = 4'b0010;
    repeat (30) @(negedge clock);
    req = 4'b0000;
    repeat (6) @(negedge clock);

    // Arbitration: 3,2,1 together; 3 waits; expiry of 1 and grant of 3 are one edge apart,
    // and expiry of 2 coincides with the grant of 3
    dur_cfg = durs(16'd100, 16'd100, 16'd100, 16'd100);
    t = cyc;
    push(t + 3,   4'b0000, 2'd0, 1'b1, 1'b0);
    push(t + 4,   4'b0010, 2'd1, 1'b1, 1'b0);
    push(t + 5,   4'b0110, 2'd2, 1'b1, 1'b0);
    push(t + 104, 4'b0100, 2'd1, 1'b1, 1'b0);
    push(t + 105, 4'b1000, 2'd1, 1'b1, 1'b0);
    push(t + 205, 4'b0000, 2'd0, 1'b0, 1'b0);
    req = 4'b1110;
    repeat (210) @(negedge clock);
    req = 4'b0000;
    repeat (6) @(negedge clock);

    // Preemption: 2 and 3 running, request 0 kills 3 which never resumes
    dur_cfg = durs(16'd50, 16'd50, 16'd0, 16'd4);
    t = cyc;
    push(t + 3,  4'b0000, 2'd0, 1'b1, 1'b0);
    push(t + 4,  4'b0100, 2'd1, 1'b1, 1'b0);
    push(t + 5,  4'b1100, 2'd2, 1'b1, 1'b0);
    push(t + 10, 4'b0100, 2'd1, 1'b1, 1'b1);
    push(t + 11, 4'b0101, 2'd2, 1'b1, 1'b0);
    push(t + 15, 4'b0100, 2'd1, 1'b1, 1'b0);
    push(t + 54, 4'b0000, 2'd0, 1'b0, 1'b0);
    req = 4'b1100;
    repeat (6) @(negedge clock);
    req = 4'b1101;
    repeat (55) @(negedge clock);
    req = 4'b0000;
    repeat (6) @(negedge clock);

    // Reset with two voices running; held request levels must not restart anything
    dur_cfg = durs(16'd0, 16'd30, 16'd30, 16'd0);
    t = cyc;
    push(t + 3, 4'b0000, 2'd0, 1'b1, 1'b0);
    push(t + 4, 4'b0010, 2'd1, 1'b1, 1'b0);
    push(t + 5, 4'b0110, 2'd2, 1'b1, 1'b0);
    push(t + 9, 4'b0000, 2'd0, 1'b0, 1'b0);
    req = 4'b0110;
    repeat (8) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (20) @(negedge clock);

    done = 1'b1;
  end

endmodule
